// File: rtl/adder_share_arb.sv
// adder_share_arb
//   Shares one 32-bit carry-select adder among NREQ requesters.
//   Requesters are arbitrated round-robin, and only the winner's operands
//   reach the adder. The sum, carry-out and winner ID are captured in one
//   registered result slot. A result is visible one cycle after the request
//   is accepted. A full slot that is drained in a cycle can be refilled in
//   that same cycle, so the block sustains one result per cycle.
//
//   Optional feature: define ADDER_ARB_LOCK_EN to add the req_lock input.
//   When the accepted requester has its lock bit set, the round-robin
//   pointer stays on that requester, so it wins again on the next cycle.
//   This supports back-to-back multi-word adds.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]      per-requester operation valid
//   req_a      in   [32*NREQ]   operand A, slice i = [32*i+31:32*i]
//   req_b      in   [32*NREQ]   operand B, same slicing
//   req_cin    in   [NREQ]      per-requester carry-in
//   req_lock   in   [NREQ]      (ADDER_ARB_LOCK_EN only) hold priority
//   req_ready  out  [NREQ]      one-hot accept
//   rsp_valid  out              result slot full
//   rsp_ready  in               consumer takes the result
//   rsp_sum    out  [32]        registered sum
//   rsp_cout   out              registered carry-out
//   rsp_id     out  [IDW]       requester that produced the result
//
// Result slot FSM
//   state      | meaning
//   SLOT_EMPTY | no result held, rsp_valid = 0
//   SLOT_FULL  | result held until rsp_ready, rsp_valid = 1

module carry_select #(
  parameter int W   = 32,
  parameter int BLK = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NBLK = W / BLK;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  // Each block precomputes its result for both carry-in values. The
  // incoming carry then only drives a mux, which keeps the carry path short.
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] sum0;
    logic [BLK:0] sum1;

    assign sum0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
    assign sum1 = sum0 + {{BLK{1'b0}}, 1'b1};

    assign sum[g*BLK +: BLK] = carry[g] ? sum1[BLK-1:0] : sum0[BLK-1:0];
    assign carry[g+1]        = carry[g] ? sum1[BLK]     : sum0[BLK];
  end

  assign cout = carry[NBLK];

endmodule

module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
`ifdef ADDER_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic [IDW-1:0]       rsp_id
);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0]     slot_state;
  logic [IDW-1:0] rr_ptr;

  logic           accept_ok;
  logic           any_valid;
  logic [IDW-1:0] winner;
  logic           accept;
  logic [IDW-1:0] ptr_adv;
  logic [IDW-1:0] ptr_next;

  logic [31:0]    a_sel;
  logic [31:0]    b_sel;
  logic           cin_sel;
  logic [31:0]    sum_w;
  logic           cout_w;

  assign rsp_valid = (slot_state == SLOT_FULL);
  assign accept_ok = ~rsp_valid | rsp_ready;

  // Round-robin scan that starts at rr_ptr and wraps modulo NREQ. The
  // first valid requester found wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    for (int k = 0; k < NREQ; k++) begin
      int pos;
      pos = int'(rr_ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      if (!any_valid && req_valid[IDW'(pos)]) begin
        any_valid = 1'b1;
        winner    = IDW'(pos);
      end
    end
  end

  // rst_n gates req_ready so that nothing is granted while in reset, even
  // though the empty slot would otherwise allow an accept.
  assign accept = any_valid & accept_ok & rst_n;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept & (winner == IDW'(i));
    end
  end

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        a_sel   = req_a[32*i +: 32];
        b_sel   = req_b[32*i +: 32];
        cin_sel = req_cin[i];
      end
    end
  end

  carry_select #(
    .W   (32),
    .BLK (8)
  ) u_adder (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (cin_sel),
    .sum  (sum_w),
    .cout (cout_w)
  );

  assign ptr_adv = (winner == IDW'(NREQ-1)) ? '0 : winner + {{(IDW-1){1'b0}}, 1'b1};

`ifdef ADDER_ARB_LOCK_EN
  // A locked winner keeps priority for its next word.
  assign ptr_next = req_lock[winner] ? winner : ptr_adv;
`else
  assign ptr_next = ptr_adv;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_state <= SLOT_EMPTY;
      rr_ptr     <= '0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
    end else begin
      if (accept) begin
        slot_state <= SLOT_FULL;
        rsp_sum    <= sum_w;
        rsp_cout   <= cout_w;
        rsp_id     <= winner;
        rr_ptr     <= ptr_next;
      end else if (slot_state == SLOT_FULL && rsp_ready) begin
        // When the slot drains with no refill, the data fields keep their
        // last values.
        slot_state <= SLOT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
`ifdef ADDER_ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock;
`endif
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_sum;
  logic                 rsp_cout;
  logic [IDW-1:0]       rsp_id;

  int errors = 0;
  int checks = 0;

  // Reference model: pointer, slot contents, last accept decision
  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_sum;
  logic        m_cout;
  int          m_id;
  logic        m_acc;
  int          m_win;

  always #5 clk = ~clk;

  adder_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  function automatic int mdl_winner(logic [NREQ-1:0] v, int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic lock_of(int w);
`ifdef ADDER_ARB_LOCK_EN
    return req_lock[w];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int w;
    logic [NREQ-1:0] r;
    r = '0;
    w = mdl_winner(req_valid, m_ptr);
    if (w >= 0 && (!m_valid || rsp_ready)) r[w] = 1'b1;
    return r;
  endfunction

  task automatic mdl_reset();
    m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_id = 0;
    m_acc = 1'b0; m_win = -1;
  endtask

  task automatic set_op(int i, logic [31:0] a, logic [31:0] b, logic c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = c;
  endtask

  // Advance one clock and update the model. Returns at posedge + 1.
  task automatic cycle();
    int w;
    logic acc;
    logic [32:0] s;
    w   = mdl_winner(req_valid, m_ptr);
    acc = (w >= 0) && (!m_valid || rsp_ready);
    @(posedge clk);
    if (acc) begin
      s = 33'(req_a[32*w +: 32]) + 33'(req_b[32*w +: 32]) + 33'(req_cin[w]);
      m_sum   = s[31:0];
      m_cout  = s[32];
      m_id    = w;
      m_valid = 1'b1;
      m_ptr   = lock_of(w) ? w : (w + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 1'b0;
    end
    m_acc = acc;
    m_win = w;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
`ifdef ADDER_ARB_LOCK_EN
    req_lock = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    req_cin = '0;
`ifdef ADDER_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'($urandom));
    #12;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b sum=%h cout=%b id=%0d, expected all zero",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
    mdl_reset();
  endtask

  task automatic test_basic();
    req_valid = 4'b0001;
    set_op(0, 32'h5, 32'h3, 1'b1);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL basic_ready: got %b expected 0001", req_ready);
    end
    cycle();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h9 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL basic_rsp: got valid=%b sum=%h cout=%b id=%0d, expected 1 00000009 0 0",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'($urandom));
    for (int c = 0; c < 8; c++) begin
      logic [NREQ-1:0] exp;
      exp = '0;
      exp[c % NREQ] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== exp) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, exp);
      end
      cycle();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(c % NREQ) || rsp_sum !== m_sum || rsp_cout !== m_cout) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: got valid=%b id=%0d sum=%h cout=%b, expected 1 %0d %h %b",
                 c, rsp_valid, rsp_id, rsp_sum, rsp_cout, c % NREQ, m_sum, m_cout);
      end
      set_op(c % NREQ, $urandom, $urandom, 1'($urandom));
    end
    req_valid = '0;
  endtask

  task automatic test_carry();
    req_valid = 4'b0100;
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL carry_ready: got %b expected 0100", req_ready);
    end
    cycle();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL carry_rsp: got valid=%b sum=%h cout=%b id=%0d, expected 1 00000000 1 2",
               rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
  endtask

  task automatic test_stall();
    logic [31:0] snap_sum;
    logic        snap_cout;
    int          snap_id;
    // Accept from requester 0 while the slot is full and draining. This
    // leaves the pointer at 1.
    req_valid = 4'b0001;
    set_op(0, $urandom, $urandom, 1'($urandom));
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall_refill: got %b expected 0001", req_ready);
    end
    cycle();
    snap_sum = m_sum; snap_cout = m_cout; snap_id = m_id;
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    set_op(1, $urandom, $urandom, 1'($urandom));
    set_op(3, $urandom, $urandom, 1'($urandom));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_ready[%0d]: got %b expected 0000", c, req_ready);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== snap_sum || rsp_cout !== snap_cout || rsp_id !== IDW'(snap_id)) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b sum=%h cout=%b id=%0d, expected 1 %h %b %0d",
                 c, rsp_valid, rsp_sum, rsp_cout, rsp_id, snap_sum, snap_cout, snap_id);
      end
      cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_release: got %b expected 0010", req_ready);
    end
    cycle();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== m_sum || rsp_cout !== m_cout) begin
      errors++;
      $display("FAIL stall_result: got valid=%b id=%0d sum=%h, expected 1 1 %h",
               rsp_valid, rsp_id, rsp_sum, m_sum);
    end
  endtask

  task automatic test_async_reset();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== '0 || rsp_sum !== 32'h0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b sum=%h id=%0d, expected 0 0000 0 0",
               rsp_valid, req_ready, rsp_sum, rsp_id);
    end
    #1;
    rst_n = 1'b1;
    mdl_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    set_op(3, $urandom, $urandom, 1'($urandom));
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL async_grant3: got %b expected 1000", req_ready);
    end
    cycle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== m_sum) begin
      errors++;
      $display("FAIL async_rsp3: got valid=%b id=%0d sum=%h, expected 1 3 %h",
               rsp_valid, rsp_id, rsp_sum, m_sum);
    end
    // After granting requester 3 the pointer wraps to 0.
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, 1'($urandom));
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL async_wrap: got %b expected 0001", req_ready);
    end
    cycle();
    req_valid = '0;
  endtask

  task automatic test_lock();
`ifdef ADDER_ARB_LOCK_EN
    apply_reset();
    req_valid = 4'b0110;
    req_lock  = 4'b0010;
    set_op(1, $urandom, $urandom, 1'($urandom));
    set_op(2, $urandom, $urandom, 1'($urandom));
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL lock_first: got %b expected 0010", req_ready);
    end
    cycle();
    req_lock = 4'b0000;
    set_op(1, $urandom, $urandom, 1'($urandom));
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL lock_second: got %b expected 0010", req_ready);
    end
    cycle();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL lock_release: got %b expected 0100", req_ready);
    end
    cycle();
    req_valid = '0;
    checks++;
    if (rsp_id !== 2'd2 || rsp_sum !== m_sum) begin
      errors++;
      $display("FAIL lock_rsp: got id=%0d sum=%h, expected 2 %h", rsp_id, rsp_sum, m_sum);
    end
`endif
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i] = 1'b1;
          case ($urandom_range(0, 3))
            0:       set_op(i, 32'hFFFF_FFFF, $urandom_range(0, 2), 1'($urandom));
            default: set_op(i, $urandom, $urandom, 1'($urandom));
          endcase
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ADDER_ARB_LOCK_EN
      req_lock = 4'($urandom_range(0, 15));
`endif
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_ready());
      end
      checks++;
      if (rsp_valid !== m_valid || rsp_sum !== m_sum || rsp_cout !== m_cout || rsp_id !== IDW'(m_id)) begin
        errors++;
        $display("FAIL rand_rsp[%0d]: got valid=%b sum=%h cout=%b id=%0d, expected %b %h %b %0d",
                 c, rsp_valid, rsp_sum, rsp_cout, rsp_id, m_valid, m_sum, m_cout, m_id);
      end
      cycle();
      if (m_acc) req_valid[m_win] = 1'b0;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    req_a = '0;
    req_b = '0;
    mdl_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_carry();
    test_stall();
    test_async_reset();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Shares one 32-bit carry-select adder (team module carry_select) among NREQ requesters, e.g. ALU, address generator and branch-target unit.
- Round-robin arbitration with a valid/ready handshake on each request port.
- One registered result slot, so a result appears one cycle after acceptance, tagged with the requester ID.
- Sits between the processor's execute-stage requesters and the shared adder datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width, must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester operation valid
req_a  input  32*NREQ  operand A; slice i = bits [32*i+31:32*i]
req_b  input  32*NREQ  operand B, same slicing
req_cin  input  NREQ  per-requester carry-in
req_ready  output  NREQ  one-hot accept; request i transfers when req_valid[i] & req_ready[i]
rsp_valid  output  1  result slot full
rsp_ready  input  1  consumer accepts result
rsp_sum  output  32  registered sum
rsp_cout  output  1  registered carry-out
rsp_id  output  IDW  index of requester that produced the result

Behaviour:
- Reset (async, rst_n low): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rr_ptr=0. req_ready is 0 while in reset.
- Slot state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- accept_ok = ~rsp_valid | rsp_ready. A FULL slot being drained this cycle may refill in the same cycle, giving 1 result/cycle throughput.
- Arbitration is combinational each cycle: scan req_valid from rr_ptr upward, wrapping modulo NREQ; the first set bit is the winner.
- req_ready = onehot(winner) when accept_ok and any req_valid; otherwise req_ready = 0.
- req_ready never depends on req_a, req_b or req_cin. It does depend on req_valid.
- Datapath: the winner's a, b and cin are muxed into the single carry_select instance.
- On accept, the next edge loads rsp_sum, rsp_cout and rsp_id=winner, and sets rsp_valid=1.
- Latency: exactly 1 cycle from the accept edge to rsp_valid.
- After an accept, rr_ptr = (winner+1) mod NREQ. rr_ptr is unchanged when there is no accept.
- Drain without refill (rsp_valid & rsp_ready, no accept): rsp_valid falls to 0. rsp_sum, rsp_cout and rsp_id hold their last values.
- Stall (rsp_valid & ~rsp_ready): all rsp_* outputs are held stable; req_ready = 0.
- Requesters must hold valid and operands stable until accepted. The arbiter never drops an accepted request.
- Wrap-around: if rr_ptr = NREQ-1 and only requester 0 is valid, requester 0 is granted and rr_ptr becomes 1.
- Single active requester: it is granted every cycle the slot allows; no bubbles are inserted.
- Arithmetic: sum and carry-out are the 33-bit result of a+b+cin, modulo 2**32 plus carry. No flags other than cout.
- Reset mid-operation: an in-flight result is discarded, rsp_valid goes to 0 immediately (async), and arbitration restarts from requester 0.

Optional Feature:
- Macro: ADDER_ARB_LOCK_EN.
- When defined, adds input req_lock (width NREQ).
- If the accepted requester has req_lock[winner]=1, rr_ptr stays at winner instead of advancing. The same requester then wins the next cycle if it is still valid, which supports back-to-back multi-word adds.
- Lock never overrides a stalled slot.
- When not defined: the port is absent and rr_ptr always advances as above.

Test Plan:
- Reset, then req_valid=0001, a=0x0000_0005, b=0x0000_0003, cin=1, rsp_ready=1 -> req_ready=0001. Next cycle: rsp_valid=1, rsp_sum=0x9, rsp_cout=0, rsp_id=0.
- All four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence matches the grant order; no idle cycles.
- Requester 2 with a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> rsp_sum=0x0000_0000, rsp_cout=1, rsp_id=2.
- Slot FULL and rsp_ready=0 for 3 cycles with requesters 1 and 3 valid -> req_ready=0, rsp_* stable for all 3 cycles. Then rsp_ready=1 -> requester 1 is accepted the same cycle the old result drains.
- rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 asynchronously. After release with req_valid=1000, requester 3 is granted and rr_ptr becomes 0.
- With ADDER_ARB_LOCK_EN: requester 1 valid with lock=1 and requester 2 also valid -> requester 1 is granted on two consecutive cycles. Lock then drops -> the next grant goes to requester 2.
